// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and pipe_hazard_ctrl.
// Optional PIPE_PERF_CNT_EN adds the stall/flush performance counters.
interface pipe_hazard_ctrl_if;
    logic        interrupt;
    logic        dmem_wait;
    logic        MemReadEX;
    logic [4:0]  regwriteaddrEX;
    logic [4:0]  rsID;
    logic [4:0]  rtID;
    logic        useRtID;
    logic        branch_takenEX;
    logic        jumpID;
    logic        eretID;
    logic [31:0] PCEX;

    logic        pc_write;
    logic [2:0]  pc_sel;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_flush;
    logic        ex_mem_stall;
    logic        ex_mem_flush;
    logic [31:0] epc;
    logic        kernel;
    logic        int_ack;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    modport master (
        output interrupt, dmem_wait, MemReadEX, regwriteaddrEX, rsID, rtID,
               useRtID, branch_takenEX, jumpID, eretID, PCEX,
        input  pc_write, pc_sel, if_id_stall, if_id_flush, id_ex_stall,
               id_ex_flush, ex_mem_stall, ex_mem_flush, epc, kernel, int_ack
`ifdef PIPE_PERF_CNT_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  interrupt, dmem_wait, MemReadEX, regwriteaddrEX, rsID, rtID,
               useRtID, branch_takenEX, jumpID, eretID, PCEX,
        output pc_write, pc_sel, if_id_stall, if_id_flush, id_ex_stall,
               id_ex_flush, ex_mem_stall, ex_mem_flush, epc, kernel, int_ack
`ifdef PIPE_PERF_CNT_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC enable/select, per-register stall/flush, EPC and kernel bit.
// Define PIPE_PERF_CNT_EN to add the stall_cycles / flush_events counters.
module pipe_hazard_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h8000_0004,
    parameter bit          INT_SYNC     = 1'b1
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [2:0] SEL_PC4     = 3'd0;
    localparam logic [2:0] SEL_BRANCH  = 3'd1;
    localparam logic [2:0] SEL_JUMP    = 3'd2;
    localparam logic [2:0] SEL_HANDLER = 3'd3;
    localparam logic [2:0] SEL_EPC     = 3'd4;

    typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_e;

    state_e      state_q, state_d;
    logic        int_s;
    logic        int_prev_q;
    logic        int_pending_q, int_pending_d;
    logic        kernel_q, kernel_d;
    logic        int_ack_q;
    logic [31:0] epc_q, epc_d;
    logic        take_int;
    logic        mem_hold;
    logic        load_use;

    logic        pc_write;
    logic [2:0]  pc_sel;
    logic        if_id_stall, if_id_flush;
    logic        id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush;

    generate
        if (INT_SYNC) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) sync_q <= '0;
                else       sync_q <= {sync_q[0], hz.interrupt};
            end
            assign int_s = sync_q[1];
        end else begin : g_nosync
            assign int_s = hz.interrupt;
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            int_prev_q    <= 1'b0;
            int_pending_q <= 1'b0;
            kernel_q      <= 1'b0;
            int_ack_q     <= 1'b0;
            epc_q         <= '0;
        end else begin
            state_q       <= state_d;
            int_prev_q    <= int_s;
            int_pending_q <= int_pending_d;
            kernel_q      <= kernel_d;
            int_ack_q     <= take_int;
            epc_q         <= epc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hz.dmem_wait)  state_d = MWAIT;
            MWAIT:   if (!hz.dmem_wait) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // The MWAIT cycle in which dmem_wait drops already resumes normal sequencing.
    assign mem_hold = hz.dmem_wait;
    assign load_use = hz.MemReadEX && (hz.regwriteaddrEX != 5'd0) &&
                      ((hz.regwriteaddrEX == hz.rsID) ||
                       (hz.useRtID && (hz.regwriteaddrEX == hz.rtID)));

    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    always_comb begin
        pc_write     = 1'b1;
        pc_sel       = SEL_PC4;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        take_int     = 1'b0;
        kernel_d     = kernel_q;
        epc_d        = epc_q;
        if (reset) begin
            pc_write = 1'b0;
        end else if (mem_hold) begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (int_pending_q && !kernel_q) begin
            take_int     = 1'b1;
            pc_sel       = SEL_HANDLER;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            kernel_d     = 1'b1;
            epc_d        = hz.PCEX;
        end else if (hz.branch_takenEX) begin
            pc_sel      = SEL_BRANCH;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hz.eretID && kernel_q) begin
            pc_sel      = SEL_EPC;
            if_id_flush = 1'b1;
            kernel_d    = 1'b0;
        end else if (hz.jumpID) begin
            pc_sel      = SEL_JUMP;
            if_id_flush = 1'b1;
        end
    end

    // A fresh edge in the take cycle starts a new pending request.
    assign int_pending_d = (int_pending_q && !take_int) || (int_s && !int_prev_q);

    assign hz.pc_write     = pc_write;
    assign hz.pc_sel       = pc_sel;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_stall  = id_ex_stall;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_stall = ex_mem_stall;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.epc          = epc_q;
    assign hz.kernel       = kernel_q;
    assign hz.int_ack      = int_ack_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (!pc_write) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (if_id_flush || id_ex_flush || ex_mem_flush)
                flush_events_q <= flush_events_q + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline. It generates PC write enable, PC source select, and per-register stall/flush controls for IF/ID, ID/EX and EX/MEM. Covers load-use hazards, control redirects, data-memory wait states, and interrupt entry/return. It owns EPC and the kernel-mode bit and sits beside the pipeline registers, driving their enables and clears.

Parameters:
HANDLER_ADDR, 32'h8000_0004, interrupt handler entry PC
INT_SYNC, 1, 1 = interrupt input passes through a 2-flop synchronizer; 0 = used directly

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
interrupt  input  1  external interrupt request, level
dmem_wait  input  1  data memory not ready; MEM stage must hold
MemReadEX  input  1  instruction in EX is a load
regwriteaddrEX  input  5  destination register of the EX instruction
rsID, rtID  input  5 each  source registers of the ID instruction
useRtID  input  1  ID instruction reads rt
branch_takenEX  input  1  EX branch resolved taken
jumpID  input  1  ID instruction is j/jal/jr
eretID  input  1  ID instruction is eret
PCEX  input  32  PC of the EX instruction
pc_write  output  1  PC register enable
pc_sel  output  3  0 PC+4, 1 EX branch target, 2 ID jump target, 3 HANDLER_ADDR, 4 epc
if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush  output  1 each  pipeline register hold/clear
epc  output  32  saved exception PC
kernel  output  1  interrupts masked, handler running
int_ack  output  1  one-cycle pulse, cycle after interrupt taken

Behaviour:
- Reset (async): state=RUN; epc=0; kernel=0; int_ack=0; int_pending=0; synchronizer flops 0. While reset is high, combinational outputs are forced: pc_write=0, pc_sel=0, all stall/flush=0.
- int_pending: set on a rising edge of the (optionally synchronized) interrupt. Cleared in the cycle the interrupt is taken. A new edge arriving while pending is already set is merged into the same pending.
- FSM states: RUN, MWAIT.
- RUN -> MWAIT when dmem_wait=1. MWAIT -> RUN when dmem_wait=0.
- MWAIT, and also the RUN cycle in which dmem_wait first asserts: pc_write=0; all stalls=1; no flushes; no interrupt taken; pending retained.
- RUN with dmem_wait=0 uses the following priority. Only the highest-priority active condition acts; default is pc_write=1, pc_sel=0.
- 1. Interrupt take (int_pending & !kernel): epc<=PCEX; kernel<=1; int_pending<=0; int_ack=1 next cycle; pc_sel=3; if_id_flush=id_ex_flush=ex_mem_flush=1. The EX instruction is squashed and re-executes after eret. This overrides a taken branch in EX.
- 2. branch_takenEX: pc_sel=1; if_id_flush=id_ex_flush=1.
- 3. Load-use (MemReadEX & regwriteaddrEX!=0 & (regwriteaddrEX==rsID | (useRtID & regwriteaddrEX==rtID))): pc_write=0; if_id_stall=1; id_ex_flush=1. Jump/eret in ID is deferred until the stall clears.
- 4. eretID & kernel: pc_sel=4; if_id_flush=1; kernel<=0 at the clock edge. eretID with kernel=0 is treated as a nop.
- 5. jumpID: pc_sel=2; if_id_flush=1.
- A stall and a flush are never asserted together on the same register.
- Pending interrupts while kernel=1 are held until after eret. Earliest retake is the cycle after kernel clears.
- Reset asserted mid-MWAIT or mid-redirect: immediate return to reset values; no partial EPC update.

Optional Feature:
PIPE_PERF_CNT_EN: when defined, adds outputs stall_cycles[31:0] and flush_events[31:0]. These are reset to 0 and wrap modulo 2^32.
- stall_cycles increments in each cycle with pc_write=0 outside reset.
- flush_events increments in each cycle in which any flush output is 1.
When undefined, these ports and counters do not exist.

Test Plan:
- Load-use: lw writes r8 in EX, ID reads rs=8 -> one cycle with pc_write=0, if_id_stall=1, id_ex_flush=1; next cycle normal. Same case with regwriteaddrEX=0 -> no stall.
- Branch plus load-use in the same cycle -> pc_sel=1, if_id_flush=id_ex_flush=1, pc_write=1, no stall.
- dmem_wait high for 3 cycles -> 3 cycles with all stalls=1 and pc_write=0. Interrupt edge during the wait is taken in the first cycle after dmem_wait falls.
- Interrupt with PCEX=0x0040_0020 and branch_takenEX=1 -> epc=0x0040_0020, pc_sel=3, three flushes, kernel=1, int_ack pulses the following cycle.
- Second interrupt while kernel=1 -> not taken. eretID -> pc_sel=4, kernel=0; pending interrupt is taken the next cycle.
- Reset asserted during MWAIT -> epc=0, kernel=0, pc_write=0 immediately. Macro build: counters read 0 after reset and count stalls and flushes correctly in the scenarios above.
